// File: rtl/fir_pkg.sv
// Shared definitions for the 4-parallel FIR front end: sample width, lane count,
// sample type and packer state encoding.
package fir_pkg;

    localparam int DW    = 16;
    localparam int LANES = 4;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/fir_s2p_packer.sv
// Serial-to-parallel packer: gathers 4 consecutive samples into one block and
// hands it downstream over valid/ready, using an assembly and an output register.
module fir_s2p_packer
    import fir_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] xk,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic signed [DW-1:0] x4k,
    output logic signed [DW-1:0] x4k_1,
    output logic signed [DW-1:0] x4k_2,
    output logic signed [DW-1:0] x4k_3,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t               state;
    state_t               next_state;
    logic [1:0]           idx;
    logic signed [DW-1:0] asm_q [LANES];
    logic signed [DW-1:0] out_q [LANES];
    logic signed [DW-1:0] blk   [LANES];
    logic                 accept;
    logic                 take;
    logic                 slot_free;
    logic                 complete;

    assign in_ready = (state == FILL);

    // blk is the block as it would look if closed this cycle: lanes already
    // written, the sample being accepted now, and zero padding beyond that.
    always_comb begin
        accept     = in_valid && (state == FILL);
        take       = out_valid && out_ready;
        slot_free  = !out_valid || take;
        complete   = 1'b0;
        next_state = state;
        for (int i = 0; i < LANES; i++) begin
            blk[i] = '0;
            if (2'(i) < idx)
                blk[i] = asm_q[i];
            else if ((2'(i) == idx) && accept)
                blk[i] = xk;
        end
        if (state == FILL) begin
            complete = (accept && (idx == 2'd3)) || (flush && ((idx != 2'd0) || accept));
            if (complete && !slot_free)
                next_state = FULL;
        end else if (take) begin
            next_state = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                asm_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else if (state == FILL) begin
            if (complete) begin
                idx <= '0;
                if (slot_free) begin
                    out_valid <= 1'b1;
                    for (int i = 0; i < LANES; i++)
                        out_q[i] <= blk[i];
                end else begin
                    for (int i = 0; i < LANES; i++)
                        asm_q[i] <= blk[i];
                end
            end else begin
                if (accept) begin
                    asm_q[idx] <= xk;
                    idx        <= idx + 2'd1;
                end
                if (take)
                    out_valid <= 1'b0;
            end
        end else if (take) begin
            // Held block moves straight into the output slot; out_valid stays high.
            idx <= '0;
            for (int i = 0; i < LANES; i++)
                out_q[i] <= asm_q[i];
        end
    end

    assign x4k   = out_q[0];
    assign x4k_1 = out_q[1];
    assign x4k_2 = out_q[2];
    assign x4k_3 = out_q[3];

endmodule

// File: tb/tb_fir_s2p_packer.sv
// Scoreboard bench for fir_s2p_packer: a block-level model predicts in_ready,
// out_valid and the sequence of emitted blocks; a monitor checks every presented block.
module tb_fir_s2p_packer;

    typedef logic [3:0][15:0] blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] xk = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [15:0] x4k, x4k_1, x4k_2, x4k_3;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    blk_t        exp_q[$];
    logic [15:0] cur[$];
    int          outstanding = 0;

    fir_s2p_packer #(.DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .xk        (xk),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .x4k       (x4k),
        .x4k_1     (x4k_1),
        .x4k_2     (x4k_2),
        .x4k_3     (x4k_3),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // outstanding = completed blocks not yet taken (output slot + held block)
    task automatic checkOutput();
        checks++;
        if (in_ready !== (outstanding < 2)) begin
            errors++;
            $display("[TB] FAIL in_ready got %b expected %b at %0t", in_ready, (outstanding < 2), $time);
        end
        checks++;
        if (out_valid !== (outstanding > 0)) begin
            errors++;
            $display("[TB] FAIL out_valid got %b expected %b at %0t", out_valid, (outstanding > 0), $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] x, input logic f, input logic r);
        bit   acc;
        bit   tk;
        blk_t b;
        @(negedge clk);
        checkOutput();
        in_valid  = v;
        xk        = x;
        flush     = f;
        out_ready = r;
        acc = v && (outstanding < 2);
        tk  = (outstanding > 0) && r;
        if (acc)
            cur.push_back(x);
        if (cur.size() == 4 || (f && cur.size() > 0)) begin
            b = '0;
            foreach (cur[i]) b[i] = cur[i];
            exp_q.push_back(b);
            cur.delete();
            outstanding++;
        end
        if (tk)
            outstanding--;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        checks++;
        if ({x4k, x4k_1, x4k_2, x4k_3} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_lanes got %h expected 0", {x4k, x4k_1, x4k_2, x4k_3});
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_flags got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        cur.delete();
        exp_q.delete();
        outstanding = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: whenever a block is presented it must match the oldest expected block.
    initial begin
        blk_t got;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                checks++;
                got = {x4k_3, x4k_2, x4k_1, x4k};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL block got %h expected none at %0t", got, $time);
                end else begin
                    if (got !== exp_q[0]) begin
                        errors++;
                        $display("[TB] FAIL block got %h expected %h at %0t", got, exp_q[0], $time);
                    end
                    if (out_ready)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        doReset();
        applyStimulus(1'b1, 16'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd6, 1'b0, 1'b1);
        doReset();

        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(-16 + i), 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'hdead, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        applyStimulus(1'b1, 16'h7fff, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h8000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(200 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        // flush together with first-lane accept, then with the completing accept
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(300 + i), 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0abc, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom % 4) != 0, 16'($urandom), ($urandom % 10) == 0, ($urandom % 3) != 0);

        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d blocks left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
